// File: rtl/vc_rr_allocator.sv
// rtl/vc_rr_allocator.sv - Virtual-channel and switch allocator with per-output round-robin and credit flow control
//
// Purpose: accepts one flit per input per cycle, assigns a downstream VC to head
// flits, keeps packets on their VC until the tail, and grants at most one input
// per output per cycle. All outputs are registered: a request seen at one edge
// is reported as a grant in the cycle that follows.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   req_valid/head/tail    per-input flit request and packet framing
//   req_out                per-input requested output index (PW bits each)
//   credit_ret             per output/VC one-cycle credit-return pulse
//   grant, grant_vc        per-input acceptance and assigned downstream VC
//   out_valid, xbar_sel    per-output flit valid and selected input index
//   occupied               per output/VC busy bits
//   stall_cnt              per-output 16-bit saturating stall counters
//                          (present only when VC_ALLOC_STATS_EN is defined)
module vc_rr_allocator #(
    parameter int PORT_CNT     = 7,
    parameter int VC_NUM       = 4,
    parameter int CREDIT_DEPTH = 4,
    localparam int PW = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1,
    localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORT_CNT-1:0]          req_valid,
    input  logic [PORT_CNT-1:0]          req_head,
    input  logic [PORT_CNT-1:0]          req_tail,
    input  logic [PORT_CNT*PW-1:0]       req_out,
    input  logic [PORT_CNT*VC_NUM-1:0]   credit_ret,
    output logic [PORT_CNT-1:0]          grant,
    output logic [PORT_CNT*VW-1:0]       grant_vc,
    output logic [PORT_CNT-1:0]          out_valid,
    output logic [PORT_CNT*PW-1:0]       xbar_sel,
    output logic [PORT_CNT*VC_NUM-1:0]   occupied
`ifdef VC_ALLOC_STATS_EN
    ,
    output logic [PORT_CNT*16-1:0]       stall_cnt
`endif
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int NV = PORT_CNT * VC_NUM;

    // Per output/VC state, flat index = output*VC_NUM + vc
    logic [NV-1:0]       busy_q, busy_d;
    logic [PW-1:0]       owner_q [NV];
    logic [PW-1:0]       owner_d [NV];
    logic [CW-1:0]       credit_q [NV];
    logic [CW-1:0]       credit_d [NV];

    // Per input lock state and per output arbitration pointer
    logic [PORT_CNT-1:0] lock_q, lock_d;
    logic [PW-1:0]       lock_out_q [PORT_CNT];
    logic [PW-1:0]       lock_out_d [PORT_CNT];
    logic [VW-1:0]       lock_vc_q [PORT_CNT];
    logic [VW-1:0]       lock_vc_d [PORT_CNT];
    logic [PW-1:0]       ptr_q [PORT_CNT];
    logic [PW-1:0]       ptr_d [PORT_CNT];

    // Registered outputs
    logic [PORT_CNT-1:0]        grant_q, grant_d;
    logic [PORT_CNT*VW-1:0]     grant_vc_q, grant_vc_d;
    logic [PORT_CNT-1:0]        out_valid_q, out_valid_d;
    logic [PORT_CNT*PW-1:0]     xbar_sel_q, xbar_sel_d;

    // Per input request decode
    logic [PORT_CNT-1:0] pend;     // legal request (not dropped)
    logic [PORT_CNT-1:0] res_ok;   // downstream resources available
    logic [PORT_CNT-1:0] elig;
    logic [PW-1:0]       tgt  [PORT_CNT];
    logic [VW-1:0]       vsel [PORT_CNT];

    // Per output arbitration result
    logic [PORT_CNT-1:0] won;
    logic [PW-1:0]       win [PORT_CNT];
    int                  arb_idx;

    logic [NV-1:0]       dec;
    int                  w_idx;
    int                  slot;

    always_comb begin : eligibility
        for (int i = 0; i < PORT_CNT; i++) begin
            pend[i]   = 1'b0;
            res_ok[i] = 1'b0;
            tgt[i]    = req_out[i*PW +: PW];
            vsel[i]   = '0;
            if (req_valid[i]) begin
                if (req_head[i] && !lock_q[i] && (int'(req_out[i*PW +: PW]) < PORT_CNT)) begin
                    pend[i] = 1'b1;
                    // Scan downward so the lowest free VC with credit is the one kept
                    for (int v = VC_NUM - 1; v >= 0; v--) begin
                        if (!busy_q[int'(tgt[i])*VC_NUM + v] &&
                            (credit_q[int'(tgt[i])*VC_NUM + v] != '0)) begin
                            res_ok[i] = 1'b1;
                            vsel[i]   = VW'(v);
                        end
                    end
                end else if (!req_head[i] && lock_q[i]) begin
                    // Body/tail follow the lock; req_out is not consulted
                    pend[i]   = 1'b1;
                    tgt[i]    = lock_out_q[i];
                    vsel[i]   = lock_vc_q[i];
                    res_ok[i] = (credit_q[int'(lock_out_q[i])*VC_NUM + int'(lock_vc_q[i])] != '0) &&
                                (owner_q[int'(lock_out_q[i])*VC_NUM + int'(lock_vc_q[i])] == PW'(i));
                end
            end
            elig[i] = pend[i] && res_ok[i];
        end
    end

    always_comb begin : arbitrate
        arb_idx = 0;
        for (int o = 0; o < PORT_CNT; o++) begin
            won[o] = 1'b0;
            win[o] = '0;
            for (int k = 0; k < PORT_CNT; k++) begin
                arb_idx = (int'(ptr_q[o]) + k) % PORT_CNT;
                if (!won[o] && elig[arb_idx] && (int'(tgt[arb_idx]) == o)) begin
                    won[o] = 1'b1;
                    win[o] = PW'(arb_idx);
                end
            end
        end
    end

    always_comb begin : next_state
        busy_d      = busy_q;
        owner_d     = owner_q;
        credit_d    = credit_q;
        lock_d      = lock_q;
        lock_out_d  = lock_out_q;
        lock_vc_d   = lock_vc_q;
        ptr_d       = ptr_q;
        grant_d     = '0;
        grant_vc_d  = '0;
        out_valid_d = '0;
        xbar_sel_d  = '0;
        dec         = '0;
        w_idx       = 0;
        slot        = 0;
        for (int o = 0; o < PORT_CNT; o++) begin
            if (won[o]) begin
                w_idx = int'(win[o]);
                slot  = o*VC_NUM + int'(vsel[w_idx]);
                ptr_d[o]                   = PW'((w_idx + 1) % PORT_CNT);
                grant_d[w_idx]             = 1'b1;
                grant_vc_d[w_idx*VW +: VW] = vsel[w_idx];
                out_valid_d[o]             = 1'b1;
                xbar_sel_d[o*PW +: PW]     = win[o];
                dec[slot]                  = 1'b1;
                if (req_head[w_idx]) begin
                    busy_d[slot]      = 1'b1;
                    owner_d[slot]     = win[o];
                    lock_d[w_idx]     = 1'b1;
                    lock_out_d[w_idx] = PW'(o);
                    lock_vc_d[w_idx]  = vsel[w_idx];
                end
                // Tail wins over head so a single-flit packet leaves nothing held
                if (req_tail[w_idx]) begin
                    busy_d[slot]  = 1'b0;
                    lock_d[w_idx] = 1'b0;
                end
            end
        end
        for (int s = 0; s < NV; s++) begin
            if (dec[s] && !credit_ret[s]) begin
                credit_d[s] = credit_q[s] - CW'(1);
            end else if (!dec[s] && credit_ret[s] && (credit_q[s] != CW'(CREDIT_DEPTH))) begin
                credit_d[s] = credit_q[s] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            lock_q      <= '0;
            grant_q     <= '0;
            grant_vc_q  <= '0;
            out_valid_q <= '0;
            xbar_sel_q  <= '0;
            for (int s = 0; s < NV; s++) begin
                owner_q[s]  <= '0;
                credit_q[s] <= CW'(CREDIT_DEPTH);
            end
            for (int i = 0; i < PORT_CNT; i++) begin
                lock_out_q[i] <= '0;
                lock_vc_q[i]  <= '0;
                ptr_q[i]      <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            credit_q    <= credit_d;
            lock_q      <= lock_d;
            lock_out_q  <= lock_out_d;
            lock_vc_q   <= lock_vc_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_vc_q  <= grant_vc_d;
            out_valid_q <= out_valid_d;
            xbar_sel_q  <= xbar_sel_d;
        end
    end

    assign grant     = grant_q;
    assign grant_vc  = grant_vc_q;
    assign out_valid = out_valid_q;
    assign xbar_sel  = xbar_sel_q;
    assign occupied  = busy_q;

`ifdef VC_ALLOC_STATS_EN
    logic [15:0]         stall_q [PORT_CNT];
    logic [15:0]         stall_d [PORT_CNT];
    logic [PORT_CNT-1:0] stalled;

    // An output stalls when any legal request aimed at it is left ungranted
    always_comb begin : stall_next
        stalled = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            if (pend[i] && !grant_d[i]) begin
                stalled[int'(tgt[i])] = 1'b1;
            end
        end
        for (int o = 0; o < PORT_CNT; o++) begin
            stall_d[o] = stall_q[o];
            if (stalled[o] && (stall_q[o] != 16'hFFFF)) begin
                stall_d[o] = stall_q[o] + 16'd1;
            end
            stall_cnt[o*16 +: 16] = stall_q[o];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < PORT_CNT; o++) begin
                stall_q[o] <= '0;
            end
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_vc_rr_allocator.sv
// tb/tb_vc_rr_allocator.sv - Directed self-checking bench for vc_rr_allocator
module tb_vc_rr_allocator;

    localparam int P  = 7;
    localparam int V  = 4;
    localparam int PW = 3;
    localparam int VW = 2;

    logic              clk;
    logic              rst_n;
    logic [P-1:0]      req_valid;
    logic [P-1:0]      req_head;
    logic [P-1:0]      req_tail;
    logic [P*PW-1:0]   req_out;
    logic [P*V-1:0]    credit_ret;
    logic [P-1:0]      grant;
    logic [P*VW-1:0]   grant_vc;
    logic [P-1:0]      out_valid;
    logic [P*PW-1:0]   xbar_sel;
    logic [P*V-1:0]    occupied;
`ifdef VC_ALLOC_STATS_EN
    logic [P*16-1:0]   stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vc_rr_allocator #(.PORT_CNT(P), .VC_NUM(V), .CREDIT_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_head   (req_head),
        .req_tail   (req_tail),
        .req_out    (req_out),
        .credit_ret (credit_ret),
        .grant      (grant),
        .grant_vc   (grant_vc),
        .out_valid  (out_valid),
        .xbar_sel   (xbar_sel),
        .occupied   (occupied)
`ifdef VC_ALLOC_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = '0;
        req_head   = '0;
        req_tail   = '0;
        req_out    = '0;
        credit_ret = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic req(input int i, input bit h, input bit t, input int o);
        req_valid[i]         = 1'b1;
        req_head[i]          = h;
        req_tail[i]          = t;
        req_out[i*PW +: PW]  = PW'(o);
    endtask

    task automatic unreq(input int i);
        req_valid[i] = 1'b0;
        req_head[i]  = 1'b0;
        req_tail[i]  = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_vc", grant_vc, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_xsel", xbar_sel, 0);
        chk("rst_occ", occupied, 0);
        step();
        rst_n = 1'b1;

        // Round robin: 0,3,5 single-flit packets to output 2
        do_reset();
        req(0, 1, 1, 2); req(3, 1, 1, 2); req(5, 1, 1, 2);
        step();
        chk("rr_g0", grant, 7'b0000001);
        chk("rr_sel0", xbar_sel[2*PW +: PW], 0);
        chk("rr_oval0", out_valid, 7'b0000100);
        chk("rr_vc0", grant_vc[0 +: VW], 0);
        chk("rr_occ0", occupied, 0);
        unreq(0);
        step();
        chk("rr_g1", grant, 7'b0001000);
        chk("rr_sel1", xbar_sel[2*PW +: PW], 3);
        unreq(3);
        step();
        chk("rr_g2", grant, 7'b0100000);
        chk("rr_sel2", xbar_sel[2*PW +: PW], 5);
        // Pointer now at 6: input 6 beats input 5; out2/VC0 credit goes 1 -> 0
        req(5, 1, 1, 2); req(6, 1, 1, 2);
        step();
        chk("rr_ptr6", grant, 7'b1000000);
        unreq(6);
        step();
        chk("rr_g5b", grant, 7'b0100000);
        chk("rr_vc_next", grant_vc[5*VW +: VW], 1);
        idle();

        // Locked packet: input 1 head, 2 body, tail to output 4
        do_reset();
        req(1, 1, 0, 4);
        step();
        chk("pk_head_g", grant, 7'b0000010);
        chk("pk_head_vc", grant_vc[1*VW +: VW], 0);
        chk("pk_head_occ", occupied[4*V], 1);
        chk("pk_head_sel", xbar_sel[4*PW +: PW], 1);
        req(1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("pk_body_g", grant, 7'b0000010);
            chk("pk_body_vc", grant_vc[1*VW +: VW], 0);
            chk("pk_body_oval", out_valid, 7'b0010000);
            chk("pk_body_occ", occupied[4*V], 1);
        end
        req(1, 0, 1, 0);
        step();
        chk("pk_tail_g", grant, 7'b0000010);
        chk("pk_tail_vc", grant_vc[1*VW +: VW], 0);
        chk("pk_tail_occ", occupied[4*V], 0);
        unreq(1);
        step();
        chk("pk_idle_g", grant, 0);

        // Credit exhaustion; head grant coincides with a return at full credit
        do_reset();
        req(2, 1, 0, 3);
        credit_ret[3*V] = 1'b1;
        step();
        credit_ret = '0;
        chk("cr_head_g", grant[2], 1);
        req(2, 0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("cr_body_g", grant[2], (k < 4) ? 1'b1 : 1'b0);
        end
        credit_ret[3*V] = 1'b1;
        step();
        credit_ret = '0;
        chk("cr_ret_cycle", grant[2], 0);
        step();
        chk("cr_ret_grant", grant[2], 1);
        step();
        chk("cr_empty_again", grant[2], 0);
        idle();

        // Grant and return on the same VC at credit 2, then saturation at 4
        do_reset();
        req(0, 1, 0, 1);
        step();
        chk("cs_head", grant[0], 1);
        req(0, 0, 0, 1);
        step();
        chk("cs_b1", grant[0], 1);
        credit_ret[1*V] = 1'b1;
        step();
        credit_ret = '0;
        chk("cs_b2_ret", grant[0], 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("cs_tail_run", grant[0], (k < 2) ? 1'b1 : 1'b0);
        end
        unreq(0);
        credit_ret[5*V] = 1'b1;
        step();
        step();
        credit_ret = '0;
        req(3, 1, 0, 5);
        step();
        chk("sat_head", grant[3], 1);
        req(3, 0, 0, 5);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sat_body", grant[3], (k < 3) ? 1'b1 : 1'b0);
        end
        idle();

        // All VCs of output 0 busy; input 6 waits for VC2 to free up
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(i, 1, 0, 0);
            step();
            chk("vc_fill_g", grant, 64'd1 << i);
            chk("vc_fill_vc", grant_vc[i*VW +: VW], i);
            unreq(i);
        end
        chk("vc_all_busy", occupied[3:0], 4'hF);
        req(6, 1, 0, 0);
        step();
        chk("vc_block1", grant, 0);
        step();
        chk("vc_block2", grant, 0);
        req(2, 0, 1, 0);
        step();
        chk("vc_tail2", grant, 7'b0000100);
        chk("vc_freed", occupied[3:0], 4'b1011);
        unreq(2);
        step();
        chk("vc_new_g", grant, 7'b1000000);
        chk("vc_new_vc", grant_vc[6*VW +: VW], 2);
        chk("vc_new_occ", occupied[3:0], 4'hF);
        idle();

        // Reset mid-packet, then body dropped, bad port dropped, head accepted
        do_reset();
        req(4, 1, 0, 6);
        step();
        chk("mr_head", grant[4], 1);
        chk("mr_occ", occupied[6*V], 1);
        req(4, 0, 0, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_g", grant, 0);
        chk("mr_async_oval", out_valid, 0);
        chk("mr_async_occ", occupied, 0);
        chk("mr_async_sel", xbar_sel, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_body_drop1", grant, 0);
        step();
        chk("mr_body_drop2", grant, 0);
        req(4, 1, 0, 7);
        step();
        chk("mr_badport", grant, 0);
        req(4, 1, 0, 6);
        step();
        chk("mr_head_ok", grant, 7'b0010000);
        chk("mr_head_sel", xbar_sel[6*PW +: PW], 4);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
